// File: rtl/ram_arbiter_init.sv
// ram_arbiter_init
//   Owns a single-port RAM with an asynchronous read port. After reset it
//   optionally fills every location with INIT_VAL. It then shares the RAM
//   between two requesters through a req/ack handshake. Arbitration is either
//   round-robin or fixed priority, with requester 0 winning under fixed priority.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   req0/wr0/addr0/wdata0  requester 0 command (held until ack0 is sampled)
//   ack0                   one-cycle pulse: requester 0 command issued to RAM
//   rdata0/rvalid0         requester 0 read data, valid one edge after ack0
//   req1 ... rvalid1       same as above, for requester 1
//   ram_cs/ram_wr          RAM chip select / write enable (registered)
//   ram_addr/ram_din       RAM address / write data (registered)
//   ram_dout               RAM read data, combinational from ram_addr
//   init_done              high once the init sequence has finished
module ram_arbiter_init #(
   parameter int unsigned   AW        = 10,
   parameter int unsigned   DW        = 8,
   parameter int unsigned   DEPTH     = 1024,
   parameter bit            INIT_EN   = 1'b1,
   parameter logic [DW-1:0] INIT_VAL  = '0,
   parameter bit            FIXED_PRI = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          wr0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   output logic          rvalid0,
   input  logic          req1,
   input  logic          wr1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          rvalid1,
   output logic          ram_cs,
   output logic          ram_wr,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          init_done
);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   // Init counter is one bit wider than the address so it can reach DEPTH.
   localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

   state_e        state_q;
   logic [AW:0]   cnt_q;
   logic          last_q;
   logic          ram_cs_q, ram_wr_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_din_q;
   logic          ack0_q, ack1_q;
   logic          rvalid0_q, rvalid1_q;
   logic [DW-1:0] rdata0_q, rdata1_q;
   logic          init_done_q;

   logic          elig0, elig1;
   logic          gnt0_d, gnt1_d;

   // A requester that is being acked this cycle is masked out. Its command
   // inputs may already be changing, and masking it also stops back-to-back
   // grants to the same requester.
   always_comb begin
      elig0  = req0 & ~ack0_q;
      elig1  = req1 & ~ack1_q;
      gnt1_d = elig1 & (~elig0 | (~FIXED_PRI & ~last_q));
      gnt0_d = elig0 & ~gnt1_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         ram_cs_q    <= 1'b0;
         ram_wr_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         init_done_q <= 1'b0;
      end else begin
         // Read return follows the ack cycle regardless of the new grant.
         rvalid0_q <= ack0_q & ~ram_wr_q;
         rvalid1_q <= ack1_q & ~ram_wr_q;
         if (ack0_q && !ram_wr_q) rdata0_q <= ram_dout;
         if (ack1_q && !ram_wr_q) rdata1_q <= ram_dout;

         case (state_q)
            ST_INIT: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
               if (INIT_EN && (cnt_q != LAST_CNT)) begin
                  ram_cs_q   <= 1'b1;
                  ram_wr_q   <= 1'b1;
                  ram_addr_q <= cnt_q[AW-1:0];
                  ram_din_q  <= INIT_VAL;
                  cnt_q      <= cnt_q + CNT_ONE;
               end else begin
                  ram_cs_q    <= 1'b0;
                  ram_wr_q    <= 1'b0;
                  init_done_q <= 1'b1;
                  state_q     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (gnt0_d || gnt1_d) begin
                  ram_cs_q   <= 1'b1;
                  ram_wr_q   <= gnt1_d ? wr1    : wr0;
                  ram_addr_q <= gnt1_d ? addr1  : addr0;
                  ram_din_q  <= gnt1_d ? wdata1 : wdata0;
                  ack0_q     <= gnt0_d;
                  ack1_q     <= gnt1_d;
                  last_q     <= gnt1_d;
               end else begin
                  ram_cs_q <= 1'b0;
                  ram_wr_q <= 1'b0;
                  ack0_q   <= 1'b0;
                  ack1_q   <= 1'b0;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign ram_cs    = ram_cs_q;
   assign ram_wr    = ram_wr_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign init_done = init_done_q;

endmodule

// File: doc/ram_arbiter_init.md
Name: ram_arbiter_init

Overview:
- Controller that owns the single-port 1024x8 RAM (chip select, write enable, address, data in, asynchronous read out).
- After reset it runs an init sequencer that writes INIT_VAL to every location.
- It then shares the RAM between two requesters through a req/ack handshake with round-robin or fixed-priority arbitration.
- It sits between the RAM instance and the two client blocks; clients never drive the RAM directly.

Parameters:
- AW, 10, address width
- DW, 8, data width
- DEPTH, 1024, locations cleared by init (2^AW)
- INIT_EN, 1, 1 = clear the RAM after reset; 0 = skip init
- INIT_VAL, 8'h00, value written during init
- FIXED_PRI, 0, 0 = round-robin; 1 = requester 0 always wins

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 access request
- wr0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  AW  requester 0 address
- wdata0  in  DW  requester 0 write data
- ack0  out  1  one-cycle pulse: requester 0 command issued to RAM
- rdata0  out  DW  requester 0 read data
- rvalid0  out  1  one-cycle pulse: rdata0 valid
- req1, wr1, addr1, wdata1, ack1, rdata1, rvalid1: same as above, requester 1
- ram_cs  out  1  RAM chip select
- ram_wr  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, combinational from ram_addr
- init_done  out  1  high once init is complete

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state INIT; init counter 0; last-grant pointer 1 (requester 0 wins the first conflict).
- RAM contract:
  - RAM writes ram_din at the rising edge ending any cycle with ram_cs=1 and ram_wr=1.
  - ram_dout reflects ram_addr combinationally.
  - A read of the same address in the following cycle returns the new data.
- FSM has two states: INIT and RUN.
- INIT with INIT_EN=1:
  - Edge k+1 after reset release (k = 0..DEPTH-1) registers ram_cs=1, ram_wr=1, ram_addr=k, ram_din=INIT_VAL.
  - The edge after the addr DEPTH-1 cycle registers ram_cs=0, ram_wr=0, init_done=1 and moves the FSM to RUN.
  - init_done therefore rises at edge DEPTH+1 = 1025.
- INIT with INIT_EN=0: first edge goes directly to RUN with init_done=1 and no writes.
- Requests during INIT are ignored. No ack is issued; requesters hold req.
- RUN, at each edge where state is RUN before the edge:
  - eligible_i = req_i & ~ack_i, using the current registered ack. A requester is never acked on two consecutive cycles.
  - Only one eligible: that requester wins.
  - Both eligible: FIXED_PRI=0 picks the requester not equal to the last-grant pointer; FIXED_PRI=1 picks 0.
  - Winner i: register ram_cs=1, ram_wr=wr_i, ram_addr=addr_i, ram_din=wdata_i, ack_i=1, other ack=0, last-grant pointer=i.
  - No winner: ram_cs=0, ram_wr=0, both acks 0. ram_addr and ram_din hold their values.
- Handshake:
  - Requester holds req, wr, addr, wdata stable until it samples ack high.
  - In the ack cycle it may update its command or drop req. The arbiter ignores that requester at the edge ending the ack cycle.
  - Peak rate is one access per requester every 2 cycles and 100% RAM utilisation with both requesters active.
- Read return:
  - At the edge ending an ack_i cycle with ram_wr=0: rdata_i <= ram_dout and rvalid_i=1 for exactly one cycle. Latency is one edge after ack.
  - Writes produce no rvalid.
  - rdata_i holds its value between reads.
- Simultaneous events:
  - Read return for requester i and a new grant to requester j occur in the same edge independently.
  - Both rvalid pulses never occur in the same cycle.
- Reset mid-operation:
  - Asserting rst_n immediately clears all outputs, including any in-flight ack and rvalid.
  - Pending reads are lost.
  - Init restarts from address 0 on release.
- Widths: the init counter is AW+1 bits to detect the DEPTH terminal count. No wrap of ram_addr during init.

Test Plan:
- Init: release rst_n, monitor 1025 edges -> ram_cs/ram_wr high with ram_addr 0..1023 consecutive and ram_din=0x00; init_done rises at edge 1025; random read of addr 700 returns rdata=0x00.
- Single access: req0 write addr 5 data 0xAA -> ack0 one cycle, ram_wr=1 addr=5; then read addr 5 -> ack0, next cycle rvalid0=1 with rdata0=0xAA; no rvalid on the write.
- Round-robin contention: both requesters hold read requests continuously (addr0=3, addr1=4) -> ack sequence 0,1,0,1 starting with 0; ram_cs high every cycle; rvalid alternates with rdata matching each address.
- FIXED_PRI=1: requester 1 acked last cycle, both request at the same edge -> requester 0 wins; with FIXED_PRI=0 and requester 0 acked last, requester 1 wins.
- Requests during init: req0/req1 asserted from reset release -> no ack before init_done; first ack0 on the first RUN edge (edge 1026).
- Reset mid-operation: rst_n low during an ack1 read cycle -> ack1, ram_cs, rvalid1 go 0 immediately, no rvalid1 afterwards; init restarts at addr 0 after release.
